cache_req_sequencer: RTL and testbench
======================================

CACHE_REQ_SEQUENCER -- requirements
Module: cache_req_sequencer

Interface
REQ-001 SHALL have parameter OPAQUE_W, default 8, width of the opaque field.
REQ-002 SHALL have parameter ADDR_W, default 32, width of the address field.
REQ-003 SHALL have parameter DATA_W, default 32, width of the data field.
REQ-004 SHALL have parameter NUM_REQ, default 16, number of writes and reads per run (1..2^OPAQUE_W).
REQ-005 SHALL have parameter RECFG_W, default 2, width of the reconfiguration bus.
REQ-006 SHALL have parameter RECFG_WAIT, default 4, settle cycles after a reconfiguration change.
REQ-007 SHALL have parameter TIMEOUT, default 255, maximum cycles to wait for a response.
REQ-008 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-009 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-010 SHALL have these control ports:
- start, input, 1, begin a run.
- base_addr, input, ADDR_W, first address.
- stride, input, ADDR_W, address increment.
- seed, input, DATA_W, data pattern base.
- recfg_wr, input, RECFG_W, mode for the write phase.
- recfg_rd, input, RECFG_W, mode for the read phase.
REQ-011 SHALL have these cache request ports:
- cachereq_msg, output, 4+OPAQUE_W+ADDR_W+DATA_W, packed {type[1:0], opaque, addr, len[1:0], data}.
- cachereq_val, output, 1.
- cachereq_rdy, input, 1.
REQ-012 SHALL have these cache response ports:
- cacheresp_msg, input, 4+OPAQUE_W+DATA_W, packed {type[1:0], opaque, len[1:0], data}.
- cacheresp_val, input, 1.
- cacheresp_rdy, output, 1.
REQ-013 SHALL have these status ports:
- reconfiguration, output, RECFG_W.
- busy, output, 1.
- done, output, 1, run finished.
- pass, output, 1, valid with done.
- timeout, output, 1, a response wait expired.
- err_count, output, 16, saturating mismatch count.

Function
REQ-014 Type encoding SHALL be read=0, write=1; len SHALL always be 0 (full word).
REQ-015 Request i (0..NUM_REQ-1) SHALL use addr=base_addr+i*stride (mod 2^ADDR_W), opaque=i[OPAQUE_W-1:0], write data=seed+i (mod 2^DATA_W); read requests SHALL carry data 0.
REQ-016 FSM states SHALL be IDLE, WR_REQ, WR_RESP, RECFG, RD_REQ, RD_RESP, DONE.
REQ-017 IDLE: on start, SHALL latch base_addr, stride, seed, recfg_wr and recfg_rd, drive reconfiguration=recfg_wr, clear err_count and timeout, and enter WR_REQ on the next cycle.
REQ-018 In WR_REQ and RD_REQ, cachereq_val SHALL be 1 and cachereq_msg SHALL stay stable until cachereq_val&&cachereq_rdy; on transfer the FSM SHALL go to the matching *_RESP state.
REQ-019 At most one request SHALL be outstanding; cacheresp_rdy SHALL be 1 only in WR_RESP and RD_RESP.
REQ-020 On cacheresp_val&&cacheresp_rdy, a mismatch SHALL increment err_count (saturating at 16'hFFFF). A mismatch is any of:
- type differs from the request type;
- opaque differs from the request opaque;
- in RD_RESP, data differs from seed+i.
REQ-021 After a response with i<NUM_REQ-1, the FSM SHALL increment i and return to the same phase's REQ state; after i=NUM_REQ-1, WR_RESP SHALL go to RECFG and RD_RESP SHALL go to DONE.
REQ-022 RECFG: on entry SHALL reset i to 0 and drive reconfiguration=recfg_rd, then hold for exactly RECFG_WAIT cycles before entering RD_REQ; reconfiguration SHALL change only while no request is outstanding.
REQ-023 A response wait counter SHALL reset on entry to each *_RESP state; on reaching TIMEOUT with no response, timeout SHALL be set and the FSM SHALL go to DONE.
REQ-024 DONE: done=1, pass=(err_count==0 && !timeout), busy=0; done, pass, err_count and timeout SHALL hold until the next start, which restarts the run as from IDLE.
REQ-025 busy SHALL be 1 in every state except IDLE and DONE; start SHALL be ignored while busy.
REQ-026 A cacheresp_val outside the *_RESP states SHALL be ignored.

Reset
REQ-027 Reset SHALL force state IDLE and i=0.
REQ-028 Reset SHALL force all outputs to 0: val, rdy, msg, reconfiguration, busy, done, pass, timeout and err_count.
REQ-029 Reset asserted mid-run SHALL abandon the outstanding request without waiting for its response.

Structure
REQ-030 Package cache_seq_pkg SHALL hold:
- the type and len encodings;
- the state enum;
- the message field offset functions of OPAQUE_W, ADDR_W and DATA_W.
REQ-031 Sub-module cache_seq_timer SHALL implement the shared RECFG_WAIT/TIMEOUT down-counter with load and expire outputs.

Verification
REQ-032 Scenario: defaults, base=0, stride=0x100, seed=0x0a0b0c0d, ideal echo memory -> 16 writes then 16 reads, done=1, pass=1, err_count=0.
REQ-033 Scenario: recfg_wr=1, recfg_rd=2 -> reconfiguration=1 throughout writes; it changes to 2 only after the 16th write response, then exactly 4 cycles before the first read val.
REQ-034 Scenario: memory corrupts read data at address 0x200 -> err_count=1, pass=0.
REQ-035 Scenario: cachereq_rdy held low 10 cycles -> msg stable, val held, no response accepted.
REQ-036 Scenario: memory drops the 3rd read response -> timeout=1 after 255 cycles, done=1, pass=0.
REQ-037 Scenario: reset asserted during RD_RESP -> all outputs 0 immediately, state IDLE; a subsequent start runs a clean pass.

Source files
------------

// File: rtl/cache_req_sequencer_pkg.sv
// Shared definitions for the cache request sequencer.
//   - message type / len encodings
//   - sequencer FSM state enum
//   - bit offsets of each field inside the packed request/response messages
// Request  msg: {type[1:0], opaque, addr, len[1:0], data}
// Response msg: {type[1:0], opaque, len[1:0], data}
package cache_seq_pkg;

    localparam logic [1:0] TYPE_READ  = 2'd0;
    localparam logic [1:0] TYPE_WRITE = 2'd1;
    localparam logic [1:0] LEN_FULL   = 2'd0;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RECFG,
        RD_REQ,
        RD_RESP,
        DONE
    } seq_state_e;

    function automatic int req_len_lsb(int data_w);
        return data_w;
    endfunction

    function automatic int req_addr_lsb(int data_w);
        return data_w + 2;
    endfunction

    function automatic int req_opaque_lsb(int addr_w, int data_w);
        return data_w + 2 + addr_w;
    endfunction

    function automatic int req_type_lsb(int opaque_w, int addr_w, int data_w);
        return data_w + 2 + addr_w + opaque_w;
    endfunction

    function automatic int resp_len_lsb(int data_w);
        return data_w;
    endfunction

    function automatic int resp_opaque_lsb(int data_w);
        return data_w + 2;
    endfunction

    function automatic int resp_type_lsb(int opaque_w, int data_w);
        return data_w + 2 + opaque_w;
    endfunction

endpackage

// File: rtl/cache_req_sequencer_if.sv
// Cache request/response handshake bundle.
//   cachereq_*  : sequencer -> cache (msg, val) / cache -> sequencer (rdy)
//   cacheresp_* : cache -> sequencer (msg, val) / sequencer -> cache (rdy)
// master = sequencer side, slave = cache/memory side.
interface cache_req_sequencer_if #(
    parameter int OPAQUE_W = 8,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32
);
    localparam int REQ_W  = 4 + OPAQUE_W + ADDR_W + DATA_W;
    localparam int RESP_W = 4 + OPAQUE_W + DATA_W;

    logic [REQ_W-1:0]  cachereq_msg;
    logic              cachereq_val;
    logic              cachereq_rdy;
    logic [RESP_W-1:0] cacheresp_msg;
    logic              cacheresp_val;
    logic              cacheresp_rdy;

    modport master (
        output cachereq_msg, cachereq_val, cacheresp_rdy,
        input  cachereq_rdy, cacheresp_msg, cacheresp_val
    );

    modport slave (
        input  cachereq_msg, cachereq_val, cacheresp_rdy,
        output cachereq_rdy, cacheresp_msg, cacheresp_val
    );
endinterface

// File: rtl/cache_req_sequencer_timer.sv
// Shared down-counter used both for the reconfiguration settle wait and
// for the response timeout.
//   load/load_val : restart the count at load_val
//   expire        : count has reached zero (holds there until reloaded)
module cache_seq_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expire
);
    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)             cnt <= '0;
        else if (load)         cnt <= load_val;
        else if (cnt != '0)    cnt <= cnt - 1'b1;
    end

    assign expire = (cnt == '0);
endmodule

// File: rtl/cache_req_sequencer.sv
// Cache request sequencer: issues NUM_REQ writes (addr = base + i*stride,
// data = seed + i), switches reconfiguration and settles RECFG_WAIT cycles,
// then reads the same addresses back and counts mismatching responses.
//   clk, reset       : clock, async active-high reset
//   start, base_addr, stride, seed, recfg_wr, recfg_rd : run controls
//   bus (master)     : cache request/response handshakes
//   reconfiguration  : mode for the current phase
//   busy/done/pass/timeout/err_count : run status
// RECFG_WAIT and TIMEOUT must be >= 1.
module cache_req_sequencer
    import cache_seq_pkg::*;
#(
    parameter int OPAQUE_W   = 8,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int NUM_REQ    = 16,
    parameter int RECFG_W    = 2,
    parameter int RECFG_WAIT = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    base_addr,
    input  logic [ADDR_W-1:0]    stride,
    input  logic [DATA_W-1:0]    seed,
    input  logic [RECFG_W-1:0]   recfg_wr,
    input  logic [RECFG_W-1:0]   recfg_rd,
    cache_req_sequencer_if.master bus,
    output logic [RECFG_W-1:0]   reconfiguration,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic                 timeout,
    output logic [15:0]          err_count
);
    localparam int REQ_TYPE = req_type_lsb(OPAQUE_W, ADDR_W, DATA_W);
    localparam int REQ_OPQ  = req_opaque_lsb(ADDR_W, DATA_W);
    localparam int REQ_ADDR = req_addr_lsb(DATA_W);
    localparam int REQ_LEN  = req_len_lsb(DATA_W);
    localparam int RSP_TYPE = resp_type_lsb(OPAQUE_W, DATA_W);
    localparam int RSP_OPQ  = resp_opaque_lsb(DATA_W);
    localparam int RSP_LEN  = resp_len_lsb(DATA_W);
    localparam int TMR_MAX  = (TIMEOUT > RECFG_WAIT) ? TIMEOUT : RECFG_WAIT;
    localparam int TMR_W    = $clog2(TMR_MAX + 1);
    localparam logic [OPAQUE_W-1:0] LAST_IDX = OPAQUE_W'(NUM_REQ - 1);

    seq_state_e          state, next;
    logic [OPAQUE_W-1:0] idx;
    logic [ADDR_W-1:0]   cur_addr, base_q, stride_q;
    logic [DATA_W-1:0]   seed_q, exp_data;
    logic [RECFG_W-1:0]  recfg_rd_q;
    logic                tmr_load, tmr_expire;
    logic [TMR_W-1:0]    tmr_val;
    logic                in_resp, resp_fire, wait_expired, last, mismatch;
    logic [1:0]          rsp_type, exp_type, unused_rsp_len;
    logic [OPAQUE_W-1:0] rsp_opq;
    logic [DATA_W-1:0]   rsp_data;

    assign exp_data       = seed_q + DATA_W'(idx);
    assign last           = (idx == LAST_IDX);
    assign in_resp        = (state == WR_RESP) || (state == RD_RESP);
    assign resp_fire      = bus.cacheresp_val && bus.cacheresp_rdy;
    assign wait_expired   = in_resp && !bus.cacheresp_val && tmr_expire;
    assign rsp_type       = bus.cacheresp_msg[RSP_TYPE +: 2];
    assign rsp_opq        = bus.cacheresp_msg[RSP_OPQ +: OPAQUE_W];
    assign rsp_data       = bus.cacheresp_msg[0 +: DATA_W];
    assign unused_rsp_len = bus.cacheresp_msg[RSP_LEN +: 2];
    assign exp_type       = (state == WR_RESP) ? TYPE_WRITE : TYPE_READ;
    assign mismatch       = (rsp_type != exp_type) || (rsp_opq != idx) ||
                            ((state == RD_RESP) && (rsp_data != exp_data));

    cache_seq_timer #(.W(TMR_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expire   (tmr_expire)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next;
    end

    always_comb begin
        next = state;
        case (state)
            IDLE, DONE: if (start) next = WR_REQ;
            WR_REQ:     if (bus.cachereq_rdy) next = WR_RESP;
            WR_RESP: begin
                if (bus.cacheresp_val) next = last ? RECFG : WR_REQ;
                else if (tmr_expire)   next = DONE;
            end
            RECFG:      if (tmr_expire) next = RD_REQ;
            RD_REQ:     if (bus.cachereq_rdy) next = RD_RESP;
            RD_RESP: begin
                if (bus.cacheresp_val) next = last ? DONE : RD_REQ;
                else if (tmr_expire)   next = DONE;
            end
            default:    next = IDLE;
        endcase
    end

    always_comb begin
        bus.cachereq_val  = (state == WR_REQ) || (state == RD_REQ);
        bus.cacheresp_rdy = in_resp;
        busy              = (state != IDLE) && (state != DONE);
        done              = (state == DONE);
        pass              = (state == DONE) && (err_count == '0) && !timeout;
        // Timer restarts on every entry into a wait state; RESP is always
        // entered from a REQ state, so each response gets a fresh window.
        tmr_load = (next != state) &&
                   ((next == WR_RESP) || (next == RD_RESP) || (next == RECFG));
        tmr_val  = (next == RECFG) ? TMR_W'(RECFG_WAIT - 1) : TMR_W'(TIMEOUT - 1);
        bus.cachereq_msg = '0;
        if (bus.cachereq_val) begin
            bus.cachereq_msg[REQ_TYPE +: 2]        = (state == WR_REQ) ? TYPE_WRITE : TYPE_READ;
            bus.cachereq_msg[REQ_OPQ +: OPAQUE_W]  = idx;
            bus.cachereq_msg[REQ_ADDR +: ADDR_W]   = cur_addr;
            bus.cachereq_msg[REQ_LEN +: 2]         = LEN_FULL;
            bus.cachereq_msg[0 +: DATA_W]          = (state == WR_REQ) ? exp_data : '0;
        end
    end

    // Run datapath. Address is accumulated rather than multiplied.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx             <= '0;
            cur_addr        <= '0;
            base_q          <= '0;
            stride_q        <= '0;
            seed_q          <= '0;
            recfg_rd_q      <= '0;
            reconfiguration <= '0;
            err_count       <= '0;
            timeout         <= 1'b0;
        end else begin
            if (start && !busy) begin
                base_q          <= base_addr;
                stride_q        <= stride;
                seed_q          <= seed;
                recfg_rd_q      <= recfg_rd;
                reconfiguration <= recfg_wr;
                idx             <= '0;
                cur_addr        <= base_addr;
                err_count       <= '0;
                timeout         <= 1'b0;
            end
            if (resp_fire) begin
                if (mismatch && (err_count != 16'hFFFF)) err_count <= err_count + 16'd1;
                if (!last) begin
                    idx      <= idx + 1'b1;
                    cur_addr <= cur_addr + stride_q;
                end else if (state == WR_RESP) begin
                    // Last write acknowledged: nothing outstanding, safe to switch mode.
                    idx             <= '0;
                    cur_addr        <= base_q;
                    reconfiguration <= recfg_rd_q;
                end
            end
            if (wait_expired) timeout <= 1'b1;
        end
    end
endmodule

// File: tb/tb_cache_req_sequencer.sv
module tb_cache_req_sequencer;
    localparam int OW = 8, AW = 32, DW = 32, NREQ = 16, RW = 2, RWAIT = 4, TMO = 255;
    localparam int REQ_W  = 4 + OW + AW + DW;
    localparam int RESP_W = 4 + OW + DW;
    localparam int Q_ADDR = DW + 2, Q_LEN = DW, Q_OPQ = DW + 2 + AW, Q_TYPE = DW + 2 + AW + OW;

    typedef struct {
        logic [1:0]    typ;
        logic [OW-1:0] opq;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [RW-1:0] recfg;
    } req_t;

    typedef struct {
        logic [15:0] err;
        logic        tmo;
        logic        pss;
    } res_t;

    logic          clk = 1'b0, reset = 1'b1, start = 1'b0;
    logic [AW-1:0] base_addr = '0, stride = '0;
    logic [DW-1:0] seed = '0;
    logic [RW-1:0] recfg_wr = '0, recfg_rd = '0;
    logic [RW-1:0] reconfiguration;
    logic          busy, done, pass, timeout;
    logic [15:0]   err_count;

    always #5 clk = ~clk;

    cache_req_sequencer_if #(.OPAQUE_W(OW), .ADDR_W(AW), .DATA_W(DW)) bus ();

    cache_req_sequencer #(
        .OPAQUE_W(OW), .ADDR_W(AW), .DATA_W(DW), .NUM_REQ(NREQ),
        .RECFG_W(RW), .RECFG_WAIT(RWAIT), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .stride(stride), .seed(seed), .recfg_wr(recfg_wr), .recfg_rd(recfg_rd),
        .bus(bus.master), .reconfiguration(reconfiguration), .busy(busy),
        .done(done), .pass(pass), .timeout(timeout), .err_count(err_count)
    );

    int   checks = 0, failures = 0;
    req_t exp_req[$];
    res_t exp_res[$];

    // memory-side configuration, set by the stimulus between runs
    bit            corr_en = 0;
    logic [AW-1:0] corr_addr = '0;
    int            drop_idx = -1, rd_cnt = 0, stall_cnt = 0;
    logic [DW-1:0] mem [logic [AW-1:0]];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Echo memory with random ready and response latency
    initial begin : responder
        logic             req_fire, resp_fire, pend, drop;
        logic [REQ_W-1:0] m;
        logic [1:0]       typ;
        logic [AW-1:0]    a;
        logic [DW-1:0]    rdat;
        logic [RESP_W-1:0] rmsg;
        int               dly;
        bus.cachereq_rdy = 1'b0; bus.cacheresp_val = 1'b0; bus.cacheresp_msg = '0;
        pend = 1'b0; dly = 0; rmsg = '0;
        forever begin
            @(negedge clk);
            req_fire  = bus.cachereq_val && bus.cachereq_rdy;
            resp_fire = bus.cacheresp_val && bus.cacheresp_rdy;
            m         = bus.cachereq_msg;
            @(posedge clk); #1;
            if (reset) begin
                pend = 1'b0; bus.cacheresp_val = 1'b0; bus.cachereq_rdy = 1'b0;
                continue;
            end
            if (resp_fire) begin pend = 1'b0; bus.cacheresp_val = 1'b0; end
            if (req_fire) begin
                typ = m[Q_TYPE +: 2]; a = m[Q_ADDR +: AW]; drop = 1'b0;
                if (typ == 2'd1) begin
                    mem[a] = m[0 +: DW]; rdat = '0;
                end else begin
                    rdat = mem.exists(a) ? mem[a] : '0;
                    if (corr_en && a == corr_addr) rdat = rdat ^ 32'h1;
                    drop = (rd_cnt == drop_idx);
                    rd_cnt++;
                end
                if (!drop) begin
                    pend = 1'b1; dly = $urandom_range(0, 3);
                    rmsg = {typ, m[Q_OPQ +: OW], 2'b00, rdat};
                end
            end
            if (pend && !bus.cacheresp_val) begin
                if (dly == 0) begin bus.cacheresp_val = 1'b1; bus.cacheresp_msg = rmsg; end
                else dly--;
            end
            if (stall_cnt > 0) begin bus.cachereq_rdy = 1'b0; stall_cnt--; end
            else bus.cachereq_rdy = ($urandom_range(0, 3) != 0);
        end
    end

    // Scoreboard monitor
    initial begin : monitor
        int               cyc, last_chg, fire_cyc;
        logic             pv, prdy, pdone;
        logic [REQ_W-1:0] pmsg, msg;
        logic [RW-1:0]    precfg, last_wr_recfg;
        req_t             e;
        res_t             r;
        cyc = 0; last_chg = 0; fire_cyc = 0; pv = 0; prdy = 0; pdone = 0;
        pmsg = '0; precfg = '0; last_wr_recfg = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin pv = 0; prdy = 0; pdone = 0; precfg = '0; continue; end
            msg = bus.cachereq_msg;
            if (reconfiguration !== precfg) last_chg = cyc;
            precfg = reconfiguration;
            if (pv && !prdy) begin
                chk("req_hold_val", bus.cachereq_val, 1'b1);
                chk("req_hold_msg", msg, pmsg);
            end
            if (bus.cachereq_val) chk("resp_rdy_while_req", bus.cacheresp_rdy, 1'b0);
            if (bus.cachereq_val && !pv && exp_req.size() > 0 && exp_req[0].typ == 2'd0 &&
                exp_req[0].opq == '0 && exp_req[0].recfg != last_wr_recfg)
                chk("recfg_to_rd_val_gap", cyc - last_chg, RWAIT);
            if (bus.cachereq_val && bus.cachereq_rdy) begin
                chk("req_expected", exp_req.size() != 0, 1'b1);
                if (exp_req.size() != 0) begin
                    e = exp_req.pop_front();
                    chk("req_type", msg[Q_TYPE +: 2], e.typ);
                    chk("req_opaque", msg[Q_OPQ +: OW], e.opq);
                    chk("req_addr", msg[Q_ADDR +: AW], e.addr);
                    chk("req_len", msg[Q_LEN +: 2], 2'b00);
                    chk("req_data", msg[0 +: DW], e.data);
                    chk("req_reconfiguration", reconfiguration, e.recfg);
                    if (e.typ == 2'd1) last_wr_recfg = e.recfg;
                end
                fire_cyc = cyc;
            end
            if (done && !pdone) begin
                chk("res_expected", exp_res.size() != 0, 1'b1);
                if (exp_res.size() != 0) begin
                    r = exp_res.pop_front();
                    chk("err_count", err_count, r.err);
                    chk("timeout", timeout, r.tmo);
                    chk("pass", pass, r.pss);
                    chk("busy_at_done", busy, 1'b0);
                    chk("reqs_left_at_done", exp_req.size(), 0);
                    if (r.tmo) chk("timeout_latency", cyc - fire_cyc, TMO + 1);
                end
            end
            pv = bus.cachereq_val; prdy = bus.cachereq_rdy; pmsg = msg; pdone = done;
        end
    end

    // Reference: build expected request stream and run result, then start.
    task automatic launch(input logic [AW-1:0] b, input logic [AW-1:0] s, input logic [DW-1:0] sd,
                          input logic [RW-1:0] rw, input logic [RW-1:0] rr, input bit ce,
                          input logic [AW-1:0] ca, input int drop, input int stall, input bit poke);
        logic [DW-1:0] m [logic [AW-1:0]];
        logic [DW-1:0] d;
        req_t e;
        res_t r;
        int   nrd, err;
        for (int j = 0; j < NREQ; j++) begin
            e.typ = 2'd1; e.opq = OW'(j); e.addr = b + s * AW'(j); e.data = sd + DW'(j); e.recfg = rw;
            exp_req.push_back(e);
            m[e.addr] = e.data;
        end
        nrd = (drop >= 0) ? drop + 1 : NREQ;
        err = 0;
        for (int i = 0; i < nrd; i++) begin
            e.typ = 2'd0; e.opq = OW'(i); e.addr = b + s * AW'(i); e.data = '0; e.recfg = rr;
            exp_req.push_back(e);
            if (drop < 0 || i < drop) begin
                d = m[e.addr];
                if (ce && e.addr == ca) d = d ^ 32'h1;
                if (d != sd + DW'(i)) err++;
            end
        end
        r.err = 16'(err); r.tmo = (drop >= 0); r.pss = (err == 0) && (drop < 0);
        exp_res.push_back(r);
        corr_en = ce; corr_addr = ca; drop_idx = drop; rd_cnt = 0; stall_cnt = stall;
        @(posedge clk); #1;
        start = 1'b1; base_addr = b; stride = s; seed = sd; recfg_wr = rw; recfg_rd = rr;
        @(posedge clk); #1;
        start = 1'b0;
        if (poke) begin
            repeat ($urandom_range(5, 20)) @(posedge clk);
            #1;
            start = 1'b1; base_addr = $urandom; stride = $urandom; seed = $urandom;
            recfg_wr = RW'($urandom); recfg_rd = RW'($urandom);
            @(posedge clk); #1;
            start = 1'b0;
        end
    endtask

    task automatic finish_run();
        for (int n = 0; n < 4000 && exp_res.size() != 0; n++) @(negedge clk);
        chk("run_completes", exp_res.size(), 0);
        exp_res.delete(); exp_req.delete();
        repeat (3) @(negedge clk);
        chk("done_hold", done, 1'b1);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_req_val"}, bus.cachereq_val, 1'b0);
        chk({tag, "_resp_rdy"}, bus.cacheresp_rdy, 1'b0);
        chk({tag, "_req_msg"}, bus.cachereq_msg, '0);
        chk({tag, "_reconfiguration"}, reconfiguration, '0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_pass"}, pass, 1'b0);
        chk({tag, "_timeout"}, timeout, 1'b0);
        chk({tag, "_err_count"}, err_count, 16'h0);
    endtask

    initial begin : stimulus
        logic [AW-1:0] b, s;
        int            n;
        #12;
        chk_outputs_zero("reset");
        @(negedge clk); #1 reset = 1'b0;

        // ideal echo memory
        launch(32'h0, 32'h100, 32'h0a0b0c0d, 2'd0, 2'd0, 0, '0, -1, 0, 0);
        finish_run();
        // reconfiguration change between phases
        launch(32'h0, 32'h100, 32'h0a0b0c0d, 2'd1, 2'd2, 0, '0, -1, 0, 0);
        finish_run();
        // corrupt read data at 0x200
        launch(32'h0, 32'h100, 32'h0a0b0c0d, 2'd0, 2'd0, 1, 32'h200, -1, 0, 0);
        finish_run();
        // request backpressure on the first write
        launch(32'h1000, 32'h4, 32'h55aa0000, 2'd3, 2'd1, 0, '0, -1, 12, 0);
        finish_run();
        // third read response dropped
        launch(32'h0, 32'h100, 32'h0a0b0c0d, 2'd1, 2'd2, 0, '0, 2, 0, 0);
        finish_run();

        // reset while waiting on a read response
        launch(32'h0, 32'h100, 32'h0a0b0c0d, 2'd1, 2'd2, 0, '0, -1, 0, 0);
        n = 0;
        while (n < 4000 && !(exp_req.size() <= NREQ - 3 && bus.cacheresp_rdy)) begin
            @(negedge clk); n++;
        end
        chk("reached_rd_resp", bus.cacheresp_rdy, 1'b1);
        #1 reset = 1'b1;
        #1 chk_outputs_zero("midrun_reset");
        exp_req.delete(); exp_res.delete();
        repeat (2) @(posedge clk);
        @(negedge clk); #1 reset = 1'b0;
        launch(32'h0, 32'h100, 32'h0a0b0c0d, 2'd2, 2'd1, 0, '0, -1, 0, 0);
        finish_run();

        // randomized runs, including aliasing strides and ignored mid-run starts
        for (int k = 0; k < 6; k++) begin
            b = $urandom;
            case ($urandom_range(0, 3))
                0:       s = 32'h0;
                1:       s = 32'h4;
                2:       s = 32'h80000000;
                default: s = $urandom;
            endcase
            launch(b, s, $urandom, RW'($urandom), RW'($urandom), ($urandom_range(0, 1) == 1),
                   b + s * AW'($urandom_range(0, NREQ - 1)), -1, 0, 1);
            finish_run();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
